mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 22 ++
 rtl/mem_access_unit_mw_reg.sv | 22 ++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared opcodes, opcode field and FSM encoding
// Purpose: constants and types shared by the memory access stage.
// Contents: OP_LW/OP_SW opcodes, opcode field position, state_t, opcode_of().
package mem_access_unit_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_LW = 5'b01000;
  localparam logic [OPC_W-1:0] OP_SW = 5'b00111;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/mem_access_unit_mw_reg.sv
// rtl/mem_access_unit_mw_reg.sv - M/W latch register with enable and synchronous clear
// Purpose: one field of the M/W pipeline latch.
// Ports: clock, clear_n (sync active-low clear), en (load enable), d (next value), q (held value).
module mem_access_unit_mw_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline memory stage with stalling data-memory handshake
// Purpose: issues lw/sw to data memory, stalls upstream until ack, fills the M/W latch.
// Ports: clock, clear_n; X/M latch inputs ir_m, o_m, bd_m, rd_m; memory side dmem_req,
//        dmem_we, dmem_addr, dmem_wdata, dmem_ack, dmem_rdata; stall_m to upstream;
//        M/W latch outputs ir_w, o_w, d_w, rd_w.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [31:0]       ir_m,
  input  logic [31:0]       o_m,
  input  logic [31:0]       bd_m,
  input  logic [4:0]        rd_m,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              stall_m,
  output logic [31:0]       ir_w,
  output logic [31:0]       o_w,
  output logic [31:0]       d_w,
  output logic [4:0]        rd_w
);

  state_t state_q;
  state_t state_d;

  logic is_lw;
  logic is_sw;
  logic is_mem;
  logic issue;
  logic complete;
  logic load_live;

  logic [31:0] ir_d;
  logic [31:0] o_d;
  logic [31:0] d_d;
  logic [4:0]  rd_d;
  logic        mw_en;

  assign is_lw  = (opcode_of(ir_m) == OP_LW);
  assign is_sw  = (opcode_of(ir_m) == OP_SW);
  assign is_mem = is_lw || is_sw;

  // ack is only looked at in WAIT, where dmem_req is always high, so a stray
  // ack while idle (including one left over from an abandoned request) is ignored.
  always_comb begin
    state_d   = state_q;
    stall_m   = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    load_live = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          stall_m = 1'b1;
          issue   = 1'b1;
          state_d = WAIT;
        end else begin
          load_live = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          complete  = 1'b1;
          load_live = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_m = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!clear_n) begin
      stall_m = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request registers only change on issue and completion, so the address and
  // data presented to memory are stable for the whole WAIT period.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= is_sw;
      dmem_addr  <= o_m[ADDR_W-1:0];
      dmem_wdata <= bd_m;
    end else if (complete) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
    end
  end

  // The M/W latch loads every cycle: live values when the instruction retires
  // from this stage, otherwise a bubble.
  assign mw_en = 1'b1;
  assign ir_d  = load_live ? ir_m : '0;
  assign o_d   = load_live ? o_m  : '0;
  assign rd_d  = load_live ? rd_m : '0;
  assign d_d   = (complete && is_lw) ? dmem_rdata : '0;

  mem_access_unit_mw_reg #(.WIDTH(32)) u_ir_w (
    .clock(clock), .clear_n(clear_n), .en(mw_en), .d(ir_d), .q(ir_w)
  );

  mem_access_unit_mw_reg #(.WIDTH(32)) u_o_w (
    .clock(clock), .clear_n(clear_n), .en(mw_en), .d(o_d), .q(o_w)
  );

  mem_access_unit_mw_reg #(.WIDTH(32)) u_d_w (
    .clock(clock), .clear_n(clear_n), .en(mw_en), .d(d_d), .q(d_w)
  );

  mem_access_unit_mw_reg #(.WIDTH(5)) u_rd_w (
    .clock(clock), .clear_n(clear_n), .en(mw_en), .d(rd_d), .q(rd_w)
  );

endmodule
